// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, write ports, scoreboard set and state.
// The master drives indices, write data and issue requests; the slave returns data and busy state.
interface regfile_mp_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NR_RD      = 2,
  parameter int unsigned NR_WR      = 1
);
  localparam int unsigned RCNT = 2 ** ADDR_WIDTH;

  logic [NR_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NR_RD*DATA_WIDTH-1:0] rd_data;
  logic [NR_RD-1:0]            rd_busy;
  logic [NR_WR-1:0]            wr_en;
  logic [NR_WR*ADDR_WIDTH-1:0] wr_addr;
  logic [NR_WR*DATA_WIDTH-1:0] wr_data;
  logic                        sb_set_en;
  logic [ADDR_WIDTH-1:0]       sb_set_addr;
  logic [RCNT-1:0]             busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port GPR file with per-register busy scoreboard; register 0 is hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and busy release) to the read ports.
module regfile_mp #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NR_RD      = 2,
  parameter int unsigned NR_WR      = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int unsigned RCNT = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [RCNT];
  logic [RCNT-1:0]       r_busy;

  logic [ADDR_WIDTH-1:0] w_wa [NR_WR];
  logic [DATA_WIDTH-1:0] w_wd [NR_WR];
  logic [RCNT-1:0]       w_set;
  logic [RCNT-1:0]       w_clr;
  logic [RCNT-1:0]       w_busy_nxt;

  for (genvar gj = 0; gj < NR_WR; gj++) begin : g_wr
    assign w_wa[gj] = bus.wr_addr[gj*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wd[gj] = bus.wr_data[gj*DATA_WIDTH +: DATA_WIDTH];
  end

  // Issue set takes priority over writeback clear on the same edge.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (bus.sb_set_en && (bus.sb_set_addr != '0)) w_set[bus.sb_set_addr] = 1'b1;
    for (int j = 0; j < NR_WR; j++) begin
      if (bus.wr_en[j]) w_clr[w_wa[j]] = 1'b1;
    end
    w_busy_nxt    = (r_busy & ~w_clr) | w_set;
    w_busy_nxt[0] = 1'b0;
  end

  // Later ports overwrite earlier ones, so the highest-index writer wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < RCNT; r++) r_regs[r] <= '0;
      r_busy <= '0;
    end else begin
      for (int j = 0; j < NR_WR; j++) begin
        if (bus.wr_en[j] && (w_wa[j] != '0)) r_regs[w_wa[j]] <= w_wd[j];
      end
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar gi = 0; gi < NR_RD; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_bsy;

    assign w_addr = bus.rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      w_data = r_regs[w_addr];
      w_bsy  = r_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NR_WR; j++) begin
        if (bus.wr_en[j] && (w_wa[j] == w_addr)) begin
          w_data = w_wd[j];
          w_bsy  = bus.sb_set_en && (bus.sb_set_addr == w_addr);
        end
      end
`endif
      if (w_addr == '0) begin
        w_data = '0;
        w_bsy  = 1'b0;
      end
    end

    assign bus.rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = w_data;
    assign bus.rd_busy[gi]                          = w_bsy;
  end

  assign bus.busy_vec = {r_busy[RCNT-1:1], 1'b0};

endmodule
